// File: rtl/qspi_dma_pkg.sv
// Shared types and helpers for the QSPI DMA write path: scheduler state
// encoding, word size, default boundary and the chunk-size rule.
package qspi_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_DATA,
    ISSUE,
    WAIT_DONE,
    FINISH
  } wsched_state_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned DEFAULT_BOUNDARY = 4096;

  // Largest chunk that fits the remaining length, the per-transaction cap and
  // the distance to the next boundary (boundary must be a power of two).
  function automatic logic [31:0] chunk_min(input logic [31:0] remaining,
                                            input logic [31:0] cur_addr,
                                            input logic [31:0] max_chunk,
                                            input logic [31:0] boundary);
    logic [31:0] to_boundary;
    logic [31:0] capped;
    to_boundary = boundary - (cur_addr & (boundary - 32'd1));
    capped      = (remaining < max_chunk) ? remaining : max_chunk;
    return (to_boundary < capped) ? to_boundary : capped;
  endfunction

endpackage

// File: rtl/axi_write_sched_if.sv
// Command channel between the register/command layer (master) and the
// write scheduler (slave).
interface axi_write_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_len;

  modport master (output cmd_valid, output cmd_addr, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_addr, input cmd_len, output cmd_ready);
endinterface

// File: rtl/wsched_chunk_calc.sv
// Combinational chunk sizing: min(remaining, MAX_CHUNK, bytes to next
// BOUNDARY), truncated to the 16-bit write-block size field.
module wsched_chunk_calc
  import qspi_dma_pkg::*;
#(
  parameter int unsigned MAX_CHUNK = 256,
  parameter int unsigned BOUNDARY  = DEFAULT_BOUNDARY
) (
  input  logic [31:0] cur_addr,
  input  logic [31:0] remaining,
  output logic [15:0] chunk
);

  // The result never exceeds MAX_CHUNK, so the upper half is always zero.
  assign chunk = 16'(chunk_min(remaining, cur_addr, MAX_CHUNK, BOUNDARY));

endmodule

// File: rtl/axi_write_sched.sv
// Splits one long write command into boundary-safe chunks for axi_write_block.
// Optional: define WSCHED_TIMEOUT_EN to bound the wait for each chunk's done.
module axi_write_sched
  import qspi_dma_pkg::*;
#(
  parameter int unsigned MAX_CHUNK = 256,
  parameter int unsigned BOUNDARY  = DEFAULT_BOUNDARY,
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  axi_write_sched_if.slave   cmd,
  input  logic               abort,
  input  logic [LVL_W-1:0]   fifo_level,
  output logic               wb_start,
  output logic [31:0]        wb_addr,
  output logic [15:0]        wb_size,
  input  logic               wb_busy,
  input  logic               wb_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        bytes_done
);

  wsched_state_t state, state_next;
  logic [31:0]   cur_addr, remaining, remaining_left;
  logic [31:0]   level_bytes, need_bytes;
  logic [15:0]   chunk, chunk_calc;
  logic          err_flag, abort_flag;
  logic          accept, bad_cmd, level_ok, last_chunk, timed_out;

  wsched_chunk_calc #(.MAX_CHUNK(MAX_CHUNK), .BOUNDARY(BOUNDARY)) u_chunk_calc (
    .cur_addr (cur_addr),
    .remaining(remaining),
    .chunk    (chunk_calc)
  );

  assign cmd.cmd_ready  = reset && (state == IDLE);
  assign accept         = cmd.cmd_valid && cmd.cmd_ready;
  assign bad_cmd        = (cmd.cmd_len == 32'd0) || (cmd.cmd_len[1:0] != 2'b00) ||
                          (cmd.cmd_addr[1:0] != 2'b00);
  assign level_bytes    = 32'(fifo_level) * WORD_BYTES;
  // In CALC the freshly computed chunk is checked so a full FIFO issues at once.
  assign need_bytes     = {16'h0, (state == CALC) ? chunk_calc : chunk};
  assign level_ok       = level_bytes >= need_bytes;
  assign remaining_left = remaining - {16'h0, chunk};
  assign last_chunk     = (remaining_left == 32'd0) || abort_flag || abort;

  assign wb_start = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign err      = done && (err_flag || abort_flag);

`ifdef WSCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            unused_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  to_cnt <= '0;
    else if (state == ISSUE)     to_cnt <= '0;
    else if (state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
  end

  // Fires on the cycle whose edge brings the counter to TIMEOUT.
  assign timed_out = (state == WAIT_DONE) && !wb_done &&
                     ((32'(to_cnt) + 32'd1) == TIMEOUT);
  assign unused_in = wb_busy;
`else
  logic unused_in;
  assign timed_out = 1'b0;
  assign unused_in = ^{wb_busy, TIMEOUT};
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (accept) state_next = bad_cmd ? FINISH : CALC;
      CALC:      if (abort || abort_flag) state_next = FINISH;
                 else if (level_ok)       state_next = ISSUE;
                 else                     state_next = WAIT_DATA;
      WAIT_DATA: if (abort || abort_flag) state_next = FINISH;
                 else if (level_ok)       state_next = ISSUE;
      ISSUE:     state_next = WAIT_DONE;
      WAIT_DONE: if (wb_done)        state_next = last_chunk ? FINISH : CALC;
                 else if (timed_out) state_next = FINISH;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr   <= '0;
      remaining  <= '0;
      chunk      <= '0;
      bytes_done <= '0;
      wb_addr    <= '0;
      wb_size    <= '0;
      err_flag   <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      if (state == FINISH)     abort_flag <= 1'b0;
      else if (state != IDLE)  abort_flag <= abort_flag | abort;

      // Write-block outputs stay frozen from wb_start until the next issue.
      if (state_next == ISSUE && state != ISSUE) begin
        wb_addr <= cur_addr;
        wb_size <= (state == CALC) ? chunk_calc : chunk;
      end

      unique case (state)
        IDLE: if (accept) begin
          cur_addr   <= cmd.cmd_addr;
          remaining  <= cmd.cmd_len;
          bytes_done <= '0;
          err_flag   <= bad_cmd;
        end
        CALC: chunk <= chunk_calc;
        WAIT_DONE: if (wb_done) begin
          cur_addr   <= cur_addr + {16'h0, chunk};
          remaining  <= remaining_left;
          bytes_done <= bytes_done + {16'h0, chunk};
        end else if (timed_out) begin
          err_flag <= 1'b1;
        end
        FINISH:  err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_sched.sv
// Directed bench for axi_write_sched: a write-block responder checks each
// wb_start against a scoreboard of expected chunks.
module tb_axi_write_sched;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] size;
  } chunk_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic [7:0]  fifo_level;
  logic        wb_start, wb_busy, wb_done;
  logic [31:0] wb_addr, bytes_done;
  logic [15:0] wb_size;
  logic        busy, done, err;

  int     checks = 0;
  int     errors = 0;
  int     starts = 0;
  logic   hold   = 1'b0;
  chunk_t exp_q[$];

  axi_write_sched_if cmd_if ();

  axi_write_sched #(.MAX_CHUNK(256), .BOUNDARY(4096), .LVL_W(8), .TIMEOUT(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd_if),
    .abort     (abort),
    .fifo_level(fifo_level),
    .wb_start  (wb_start),
    .wb_addr   (wb_addr),
    .wb_size   (wb_size),
    .wb_busy   (wb_busy),
    .wb_done   (wb_done),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bytes_done(bytes_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Write-block model: pops the scoreboard on each start, answers after two cycles.
  always begin
    @(negedge clk);
    if (wb_start === 1'b1) begin
      chunk_t e;
      starts++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_start", wb_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", wb_addr, e.addr);
        check("sb_size", 32'(wb_size), 32'(e.size));
        if (!hold) begin
          wb_busy = 1'b1;
          repeat (2) @(negedge clk);
          check("sb_addr_stable", wb_addr, e.addr);
          check("sb_size_stable", 32'(wb_size), 32'(e.size));
          wb_done = 1'b1;
          @(negedge clk);
          wb_done = 1'b0;
          wb_busy = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [31:0] addr, input logic [15:0] size);
    chunk_t e;
    e.addr = addr;
    e.size = size;
    exp_q.push_back(e);
  endtask

  // Presents a command at a negedge and returns at the negedge after acceptance.
  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] len);
    int n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_before_send", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_len   = len;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    @(negedge clk);
    while (wb_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_start_seen"}, 32'(wb_start), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input logic [31:0] exp_bytes);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_bytes"}, bytes_done, exp_bytes);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check({tag, "_bytes_hold"}, bytes_done, exp_bytes);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_if.cmd_ready), 32'd0);
    check({tag, "_wb_start"}, 32'(wb_start), 32'd0);
    check({tag, "_wb_addr"}, wb_addr, 32'd0);
    check({tag, "_wb_size"}, 32'(wb_size), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_bytes"}, bytes_done, 32'd0);
  endtask

  initial begin
    int s0;
    int no_start;
    logic [31:0] bad_addr [3];
    logic [31:0] bad_len  [3];
    bad_addr = '{32'h100, 32'h100, 32'h102};
    bad_len  = '{32'd6,   32'd0,   32'd8};

    reset            = 1'b0;
    abort            = 1'b0;
    fifo_level       = 8'd0;
    wb_busy          = 1'b0;
    wb_done          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_len   = '0;

    repeat (2) @(negedge clk);
    check_reset("rst");
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Single chunk, FIFO already holding enough words; start two cycles after accept.
    fifo_level = 8'd4;
    push(32'h1000, 16'd16);
    send_cmd(32'h1000, 32'd16);
    @(negedge clk);
    check("single_start_latency", 32'(wb_start), 32'd1);
    wait_done("single", 1'b0, 32'd16);

    // Length cap: 256 + 256 + 88.
    fifo_level = 8'd64;
    s0 = starts;
    push(32'h0, 16'd256);
    push(32'h100, 16'd256);
    push(32'h200, 16'd88);
    send_cmd(32'h0, 32'd600);
    wait_done("split600", 1'b0, 32'd600);
    check("split600_starts", 32'(starts - s0), 32'd3);

    // 4 KB boundary split.
    s0 = starts;
    push(32'hFF0, 16'd16);
    push(32'h1000, 16'd48);
    send_cmd(32'hFF0, 32'd64);
    wait_done("boundary", 1'b0, 32'd64);
    check("boundary_starts", 32'(starts - s0), 32'd2);

    // FIFO gating: 3 words is short of 16 bytes, 4 words releases the chunk.
    fifo_level = 8'd3;
    push(32'h2000, 16'd16);
    send_cmd(32'h2000, 32'd16);
    no_start = 1;
    repeat (10) begin
      @(negedge clk);
      if (wb_start !== 1'b0) no_start = 0;
    end
    check("gate_no_start", 32'(no_start), 32'd1);
    fifo_level = 8'd4;
    @(negedge clk);
    check("gate_release_start", 32'(wb_start), 32'd1);
    wait_done("gate", 1'b0, 32'd16);

    // Abort during the first of three chunks.
    fifo_level = 8'd64;
    s0 = starts;
    push(32'h0, 16'd256);
    send_cmd(32'h0, 32'd600);
    wait_start("abort");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", 1'b1, 32'd256);
    repeat (10) @(negedge clk);
    check("abort_starts", 32'(starts - s0), 32'd1);

    // Malformed commands end with an error and never start the write block.
    s0 = starts;
    for (int i = 0; i < 3; i++) begin
      send_cmd(bad_addr[i], bad_len[i]);
      wait_done($sformatf("bad%0d", i), 1'b1, 32'd0);
    end
    check("bad_starts", 32'(starts - s0), 32'd0);

    // Reset while a chunk is outstanding.
    hold = 1'b1;
    push(32'h3000, 16'd16);
    send_cmd(32'h3000, 32'd16);
    wait_start("midrst");
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    reset = 1'b1;
    hold  = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(cmd_if.cmd_ready), 32'd1);
    check("midrst_busy_after", 32'(busy), 32'd0);

    // Recovery after reset.
    push(32'h4000, 16'd32);
    send_cmd(32'h4000, 32'd32);
    wait_done("recover", 1'b0, 32'd32);

`ifdef WSCHED_TIMEOUT_EN
    // Withheld wb_done: done/err 20 cycles after WAIT_DONE is entered.
    hold = 1'b1;
    push(32'h5000, 16'd16);
    send_cmd(32'h5000, 32'd16);
    wait_start("timeout");
    repeat (20) @(negedge clk);
    check("timeout_not_early", 32'(done), 32'd0);
    @(negedge clk);
    check("timeout_done", 32'(done), 32'd1);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_bytes", bytes_done, 32'd0);
    hold = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
